// File: rtl/nco_pkg.sv
// nco_pkg: shared waveform modes and sizing/table helpers for the NCO mixer
package nco_pkg;
   typedef enum logic [1:0] {SINE, SQUARE, SAW, OFF} wave_mode_t;
   function automatic int mix_w(input int sample_w, input int num_ch);
      return sample_w + $clog2(num_ch);
   endfunction
   function automatic int ch_w(input int num_ch);
      return (num_ch > 1) ? $clog2(num_ch) : 1;
   endfunction
   // Entry k samples the middle of its slot so the quarter mirrors without a duplicated peak
   function automatic int quarter_sine(input int k, input int sample_w, input int lut_addr_w);
      real amp;
      real q;
      amp = real'((1 << (sample_w - 1)) - 1);
      q = real'(1 << (lut_addr_w - 2));
      return $rtoi(amp * $sin(3.14159265358979 * (real'(k) + 0.5) / (2.0 * q)) + 0.5);
   endfunction
endpackage

// File: rtl/quarter_sine_lut.sv
// quarter_sine_lut: registered quarter-wave sine ROM, one cycle of latency
module quarter_sine_lut
   import nco_pkg::*;
#(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 8
) (
   input  logic                     clk_in,
   input  logic                     rst_in,
   input  logic [ADDR_W-1:0]        addr_in,
   output logic signed [DATA_W-1:0] data_out
);
   logic signed [DATA_W-1:0] rom [2**ADDR_W];
   logic signed [DATA_W-1:0] data_q, data_d;
   for (genvar k = 0; k < 2**ADDR_W; k++) begin : g_rom
      assign rom[k] = DATA_W'(quarter_sine(k, DATA_W, ADDR_W + 2));
   end
   always_comb data_d = rom[addr_in];
   always_ff @(posedge clk_in or posedge rst_in)
      if (rst_in) data_q <= '0;
      else data_q <= data_d;
   assign data_out = data_q;
endmodule

// File: rtl/nco_mixer.sv
// nco_mixer: time-multiplexed multi-channel NCO with per-channel gain, summed per frame
module nco_mixer
   import nco_pkg::*;
#(
   parameter int NUM_CH     = 4,
   parameter int PHASE_W    = 32,
   parameter int LUT_ADDR_W = 6,
   parameter int SAMPLE_W   = 8,
   parameter int GAIN_W     = 8
) (
   input  logic                                       clk_in,
   input  logic                                       rst_in,
   input  logic                                       step_in,
   input  logic                                       cfg_we_in,
   input  logic [ch_w(NUM_CH)-1:0]                    cfg_ch_in,
   input  logic [PHASE_W-1:0]                         cfg_incr_in,
   input  logic [GAIN_W-1:0]                          cfg_gain_in,
   input  logic [1:0]                                 cfg_mode_in,
   input  logic                                       cfg_phase_rst_in,
   input  logic                                       ovr_clr_in,
   output logic signed [mix_w(SAMPLE_W, NUM_CH)-1:0]  mix_out,
   output logic                                       mix_valid_out,
   output logic                                       busy_out,
   output logic                                       overrun_out
);
   localparam int MIX_W = mix_w(SAMPLE_W, NUM_CH);
   localparam int CH_W  = ch_w(NUM_CH);
   localparam int QA_W  = LUT_ADDR_W - 2;
   localparam int CNT_W = (CH_W > 2) ? CH_W : 2;
   localparam logic signed [SAMPLE_W-1:0] AMP = SAMPLE_W'((1 << (SAMPLE_W - 1)) - 1);
   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t                     state_q, state_d;
   logic [CNT_W-1:0]           cnt_q, cnt_d;
   logic [PHASE_W-1:0]         phase_q [NUM_CH], phase_d [NUM_CH];
   logic [PHASE_W-1:0]         incr_q [NUM_CH], incr_d [NUM_CH];
   logic [GAIN_W-1:0]          gain_q [NUM_CH], gain_d [NUM_CH];
   wave_mode_t                 mode_q [NUM_CH], mode_d [NUM_CH];
   logic                       v1_q, v1_d, neg1_q, neg1_d, v2_q, v2_d;
   wave_mode_t                 mode1_q, mode1_d;
   logic signed [SAMPLE_W-1:0] alt1_q, alt1_d, prod_q, prod_d;
   logic [GAIN_W-1:0]          gain1_q, gain1_d;
   logic signed [MIX_W-1:0]    acc_q, acc_d, mix_q, mix_d;
   logic                       valid_q, valid_d, busy_q, busy_d, ovr_q, ovr_d;
   logic [CH_W-1:0]            rd_ch;
   logic [PHASE_W-1:0]         rd_phase;
   logic [LUT_ADDR_W-1:0]      idx;
   logic [SAMPLE_W-1:0]        p;
   logic [QA_W-1:0]            lut_addr;
   logic signed [SAMPLE_W-1:0] lut_data, smp;
   logic signed [SAMPLE_W+GAIN_W:0] prod_full;
   logic                       reading, done, accept, cfg_ok;

   quarter_sine_lut #(.ADDR_W(QA_W), .DATA_W(SAMPLE_W)) u_lut (
      .clk_in(clk_in), .rst_in(rst_in), .addr_in(lut_addr), .data_out(lut_data)
   );

   always_comb begin
      reading  = state_q == RUN;
      done     = state_q == DRAIN && cnt_q == CNT_W'(2);
      accept   = step_in && (!busy_q || done);
      cfg_ok   = cfg_we_in && int'(cfg_ch_in) < NUM_CH;
      rd_ch    = cnt_q[CH_W-1:0];
      rd_phase = phase_q[rd_ch];
      idx      = rd_phase[PHASE_W-1 -: LUT_ADDR_W];
      p        = rd_phase[PHASE_W-1 -: SAMPLE_W];
      // Odd quadrants walk the quarter table backwards: Q-1-k is ~k
      lut_addr = idx[LUT_ADDR_W-2] ? ~idx[QA_W-1:0] : idx[QA_W-1:0];
      neg1_d   = idx[LUT_ADDR_W-1];
      alt1_d   = mode_q[rd_ch] == SQUARE ? (rd_phase[PHASE_W-1] ? -AMP : AMP)
                                         : {~p[SAMPLE_W-1], p[SAMPLE_W-2:0]};
      mode1_d  = mode_q[rd_ch];
      gain1_d  = gain_q[rd_ch];
      v1_d     = reading;
      smp      = mode1_q == SINE ? (neg1_q ? -lut_data : lut_data) : mode1_q == OFF ? '0 : alt1_q;
      prod_full = $signed({{(GAIN_W+1){smp[SAMPLE_W-1]}}, smp}) * $signed({{(SAMPLE_W+1){1'b0}}, gain1_q});
      prod_d   = SAMPLE_W'(prod_full >>> GAIN_W);
      v2_d     = v1_q;
      acc_d    = accept ? '0 : v2_q ? acc_q + MIX_W'(prod_q) : acc_q;
      mix_d    = done ? acc_q : mix_q;
      valid_d  = done;
      busy_d   = accept || (busy_q && !done);
      ovr_d    = (step_in && busy_q && !done) || (ovr_q && !ovr_clr_in);
      state_d  = state_q;
      cnt_d    = cnt_q;
      if (accept) begin
         state_d = RUN;
         cnt_d   = '0;
      end else if (reading && cnt_q == CNT_W'(NUM_CH - 1)) begin
         state_d = DRAIN;
         cnt_d   = '0;
      end else if (done) state_d = IDLE;
      else if (state_q != IDLE) cnt_d = cnt_q + CNT_W'(1);
      phase_d = phase_q;
      incr_d  = incr_q;
      gain_d  = gain_q;
      mode_d  = mode_q;
      if (reading) phase_d[rd_ch] = rd_phase + incr_q[rd_ch];
      if (cfg_ok) begin
         incr_d[cfg_ch_in] = cfg_incr_in;
         gain_d[cfg_ch_in] = cfg_gain_in;
         mode_d[cfg_ch_in] = wave_mode_t'(cfg_mode_in);
         if (cfg_phase_rst_in) phase_d[cfg_ch_in] = '0;
      end
   end

   always_ff @(posedge clk_in or posedge rst_in)
      if (rst_in) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         phase_q <= '{default: '0};
         incr_q  <= '{default: '0};
         gain_q  <= '{default: '0};
         mode_q  <= '{default: OFF};
         v1_q    <= 1'b0;
         neg1_q  <= 1'b0;
         mode1_q <= OFF;
         alt1_q  <= '0;
         gain1_q <= '0;
         v2_q    <= 1'b0;
         prod_q  <= '0;
         acc_q   <= '0;
         mix_q   <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         phase_q <= phase_d;
         incr_q  <= incr_d;
         gain_q  <= gain_d;
         mode_q  <= mode_d;
         v1_q    <= v1_d;
         neg1_q  <= neg1_d;
         mode1_q <= mode1_d;
         alt1_q  <= alt1_d;
         gain1_q <= gain1_d;
         v2_q    <= v2_d;
         prod_q  <= prod_d;
         acc_q   <= acc_d;
         mix_q   <= mix_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
         ovr_q   <= ovr_d;
      end

   assign mix_out       = mix_q;
   assign mix_valid_out = valid_q;
   assign busy_out      = busy_q;
   assign overrun_out   = ovr_q;
endmodule

// File: tb/tb_nco_mixer.sv
// tb_nco_mixer: directed frames with a scoreboard queue drained by a valid-driven monitor
module tb_nco_mixer;
   logic              clk_in = 1'b0, rst_in = 1'b1, step_in = 1'b0, cfg_we_in = 1'b0;
   logic [1:0]        cfg_ch_in = '0, cfg_mode_in = '0;
   logic [31:0]       cfg_incr_in = '0;
   logic [7:0]        cfg_gain_in = '0;
   logic              cfg_phase_rst_in = 1'b0, ovr_clr_in = 1'b0;
   logic signed [9:0] mix_out;
   logic              mix_valid_out, busy_out, overrun_out;
   int checks = 0, failures = 0, n_valid = 0, n_before;
   int sb[$];
   // q[k]-1 for k = 0..15 (gain 255 floors each positive q down by one), then idx 16 -> q[15]-1
   int sine_exp[17] = '{5, 18, 30, 42, 53, 64, 75, 84, 93, 101, 108, 114, 119, 122, 125, 126, 126};

   always #5 clk_in = ~clk_in;

   nco_mixer dut (
      .clk_in(clk_in), .rst_in(rst_in), .step_in(step_in), .cfg_we_in(cfg_we_in),
      .cfg_ch_in(cfg_ch_in), .cfg_incr_in(cfg_incr_in), .cfg_gain_in(cfg_gain_in),
      .cfg_mode_in(cfg_mode_in), .cfg_phase_rst_in(cfg_phase_rst_in), .ovr_clr_in(ovr_clr_in),
      .mix_out(mix_out), .mix_valid_out(mix_valid_out), .busy_out(busy_out), .overrun_out(overrun_out)
   );

   function automatic void check(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endfunction

   initial forever begin
      @(posedge clk_in);
      #1;
      if (mix_valid_out) begin
         n_valid++;
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_valid actual=%0d expected=no_pulse", mix_out);
         end else check("mix_out", int'(mix_out), sb.pop_front());
      end
   end

   task automatic cfg(input int ch, input logic [31:0] incr, input int gain, input int mode, input bit prst);
      @(negedge clk_in);
      cfg_we_in = 1'b1;
      cfg_ch_in = 2'(ch);
      cfg_incr_in = incr;
      cfg_gain_in = 8'(gain);
      cfg_mode_in = 2'(mode);
      cfg_phase_rst_in = prst;
      @(negedge clk_in);
      cfg_we_in = 1'b0;
      cfg_phase_rst_in = 1'b0;
   endtask

   task automatic wait_valid(input int lat, input bit idle_after);
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk_in);
         #1;
         if (mix_valid_out) begin
            check("valid_latency", i, lat);
            if (idle_after) check("busy_fall", int'(busy_out), 0);
            return;
         end
      end
      checks++;
      failures++;
      $display("FAIL valid_timeout actual=none expected=pulse_within_20");
   endtask

   task automatic frame(input int e);
      sb.push_back(e);
      @(negedge clk_in);
      step_in = 1'b1;
      @(negedge clk_in);
      step_in = 1'b0;
      check("busy_rise", int'(busy_out), 1);
      wait_valid(7, 1'b1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1);
   end

   initial begin
      repeat (3) @(negedge clk_in);
      rst_in = 1'b0;
      check("rst_mix", int'(mix_out), 0);
      check("rst_valid", int'(mix_valid_out), 0);
      check("rst_busy", int'(busy_out), 0);
      check("rst_ovr", int'(overrun_out), 0);
      frame(0);
      // square on ch0, half-cycle increment
      cfg(0, 32'h8000_0000, 255, 1, 1'b1);
      frame(126);
      frame(-127);
      frame(126);
      // sine stepping one table index per frame
      cfg(0, 32'h0400_0000, 255, 0, 1'b1);
      foreach (sine_exp[i]) frame(sine_exp[i]);
      // all channels square at phase 0
      for (int c = 0; c < 4; c++) cfg(c, 32'h0, 255, 1, 1'b1);
      frame(504);
      sb.push_back(378);
      @(negedge clk_in);
      step_in = 1'b1;
      @(negedge clk_in);
      step_in = 1'b0;
      cfg_we_in = 1'b1;
      cfg_ch_in = 2'd2;
      cfg_incr_in = '0;
      cfg_gain_in = 8'd255;
      cfg_mode_in = 2'd3;
      @(negedge clk_in);
      cfg_we_in = 1'b0;
      wait_valid(6, 1'b1);
      cfg(2, 32'h0, 255, 1, 1'b0);
      frame(504);
      // overrun: step at E0, E3 dropped, E7 accepted
      sb.push_back(504);
      @(negedge clk_in);
      step_in = 1'b1;
      @(negedge clk_in);
      step_in = 1'b0;
      @(negedge clk_in);
      @(negedge clk_in);
      step_in = 1'b1;
      @(negedge clk_in);
      step_in = 1'b0;
      check("ovr_set", int'(overrun_out), 1);
      repeat (3) @(negedge clk_in);
      sb.push_back(504);
      step_in = 1'b1;
      @(posedge clk_in);
      #1;
      check("valid_e7", int'(mix_valid_out), 1);
      check("busy_b2b", int'(busy_out), 1);
      @(negedge clk_in);
      step_in = 1'b0;
      wait_valid(7, 1'b1);
      check("ovr_sticky", int'(overrun_out), 1);
      @(negedge clk_in);
      ovr_clr_in = 1'b1;
      @(negedge clk_in);
      ovr_clr_in = 1'b0;
      check("ovr_clr", int'(overrun_out), 0);
      sb.push_back(504);
      @(negedge clk_in);
      step_in = 1'b1;
      @(negedge clk_in);
      ovr_clr_in = 1'b1;
      @(negedge clk_in);
      step_in = 1'b0;
      ovr_clr_in = 1'b0;
      check("ovr_set_wins", int'(overrun_out), 1);
      wait_valid(6, 1'b1);
      // async reset at E2 of a frame that has already advanced ch0's phase
      cfg(0, 32'h4000_0000, 255, 1, 1'b0);
      @(negedge clk_in);
      step_in = 1'b1;
      @(negedge clk_in);
      step_in = 1'b0;
      @(negedge clk_in);
      @(posedge clk_in);
      #1;
      rst_in = 1'b1;
      n_before = n_valid;
      #1;
      check("arst_mix", int'(mix_out), 0);
      check("arst_busy", int'(busy_out), 0);
      check("arst_ovr", int'(overrun_out), 0);
      check("arst_valid", int'(mix_valid_out), 0);
      repeat (2) @(negedge clk_in);
      rst_in = 1'b0;
      repeat (10) @(negedge clk_in);
      check("arst_no_pulse", n_valid, n_before);
      frame(0);
      // saw at phase 0 gives the most negative sample, proving ch0's phase was cleared
      cfg(0, 32'h0, 255, 2, 1'b0);
      frame(-128);
      repeat (3) @(negedge clk_in);
      check("sb_empty", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/nco_mixer.md
# nco_mixer

Multi-channel numerically controlled oscillator and mixer for the audio path. It generalises the single fixed-rate 8-bit sine generator in four ways:
- channel count is a parameter;
- each channel has its own runtime phase increment, gain and waveform mode;
- sine comes from a quarter-wave table;
- all channels are summed into one mix sample per `step_in` frame.

Channels are time-multiplexed through a single LUT/multiply pipeline.

## Interface
- NUM_CH, 4, number of oscillator channels (≥1)
- PHASE_W, 32, phase accumulator width
- LUT_ADDR_W, 6, full-cycle table index bits (quarter table holds Q = 2^(LUT_ADDR_W-2) entries)
- SAMPLE_W, 8, signed waveform sample width
- GAIN_W, 8, unsigned gain width; effective gain = gain/2^GAIN_W
- clk_in  in  1  clock
- rst_in  in  1  asynchronous, active-high reset
- step_in  in  1  frame request strobe (sample rate)
- cfg_we_in  in  1  config write strobe
- cfg_ch_in  in  $clog2(NUM_CH) (min 1)  target channel
- cfg_incr_in  in  PHASE_W  phase increment
- cfg_gain_in  in  GAIN_W  gain
- cfg_mode_in  in  2  0 SINE, 1 SQUARE, 2 SAW, 3 OFF
- cfg_phase_rst_in  in  1  with cfg_we_in: zero that channel's phase
- ovr_clr_in  in  1  clears overrun_out
- mix_out  out  MIX_W = SAMPLE_W+$clog2(NUM_CH)  signed mixed sample, held between frames
- mix_valid_out  out  1  one-cycle pulse when mix_out updates
- busy_out  out  1  frame in progress
- overrun_out  out  1  sticky: step_in dropped

## Operation
**Reset values.** All phases, increments and gains are 0; all modes are OFF. mix_out, mix_valid_out, busy_out and overrun_out are 0.

**Config writes.**
- Take effect at the next edge.
- Allowed while busy.
- cfg_ch_in ≥ NUM_CH: write ignored.
- cfg_phase_rst_in: the channel's phase becomes 0. This wins over a same-cycle phase update of that channel.

**Frame.**
- Accepted when step_in=1 and busy_out=0.
- Channels 0..NUM_CH-1 are read one per cycle, in order.
- A channel's sample uses its phase and config as registered in its read cycle.
- Its phase is updated with phase += incr (mod 2^PHASE_W) at the end of that read cycle, so the sample uses the pre-increment phase.

**Waveforms.** p = top SAMPLE_W phase bits; idx = top LUT_ADDR_W phase bits; A = 2^(SAMPLE_W-1)-1.
- SINE: quadrant = idx[MSB:MSB-1], k = remaining bits, q[k] = round(A·sin(π/2·(k+0.5)/Q)).
  - Quadrant 0: q[k]; quadrant 1: q[Q-1-k]; quadrant 2: -q[k]; quadrant 3: -q[Q-1-k].
- SQUARE: +A if phase MSB=0, else -A.
- SAW: {~p[MSB], p[MSB-1:0]} read as two's complement (phase 0 gives -2^(SAMPLE_W-1)).
- OFF: 0.

**Arithmetic.**
- Product = (sample × gain) >>> GAIN_W: signed × zero-extended unsigned, arithmetic (floor) shift.
- Mix = sum of NUM_CH products at MIX_W bits. Overflow is impossible, so there is no saturation.

**Overrun.**
- step_in while busy_out=1: request ignored, overrun_out←1.
- overrun_out clears only on ovr_clr_in or reset. If set and clear arrive in the same cycle, set wins.

## Timing
- Edge E0 samples an accepted step_in; busy_out rises at E0.
- Channel c read cycle: between E(c) and E(c+1).
- Pipeline stages: read → waveform/LUT register → product register → accumulate.
- At E(NUM_CH+3), mix_out loads and mix_valid_out rises for exactly one cycle; busy_out falls at the same edge.
- A step_in sampled at that edge is accepted, so back-to-back frames have a period of NUM_CH+3 cycles.
- The accumulator is cleared at frame start.
- Phase wraps modulo 2^PHASE_W.
- Reset asserted mid-frame: all state returns to reset values immediately, and no mix_valid_out pulse is produced.

## Structure
- Package `nco_pkg` holds:
  - `wave_mode_t` enum (SINE, SQUARE, SAW, OFF);
  - a constant function generating q[k] from SAMPLE_W and LUT_ADDR_W;
  - a MIX_W helper.
- Sub-module `quarter_sine_lut`: registered, parameterised (addr width, data width), contents from the package function, 1-cycle latency.
- Per-channel registers and the sequencing FSM (IDLE, RUN, DRAIN) live in the top module.

## Test plan
Defaults unless stated: NUM_CH=4, PHASE_W=32, LUT_ADDR_W=6, SAMPLE_W=8, GAIN_W=8.
1. **Reset then idle.** Reset, then step_in → mix_valid_out at E7 with mix_out=0 (all channels OFF); busy_out high E0..E7.
2. **Square on ch0.** Ch0 SQUARE, gain 255, incr 2^31; three frames → mix_out = 126, -127, 126.
3. **Sine stepping on ch0.** Ch0 SINE, gain 255, incr 2^26:
   - frame 1 → 5 (q[0]=6);
   - after 16 frames (idx 16, k=0, q[15]=127) → 126.
4. **All channels square.** All 4 channels SQUARE, gain 255, phase 0 → mix_out 504. Set ch2 OFF mid-frame, before its read cycle → that frame gives 378.
5. **Overrun.** step_in at E0 and again at E3 → single valid pulse, overrun_out=1. step_in at E7 is accepted. ovr_clr_in clears overrun_out.
6. **Async reset mid-frame.** Assert rst_in at E2 → all outputs 0 asynchronously, no valid pulse, phases 0. A following frame gives 0.
